// File: rtl/core_flst_pkg.sv
// Shared types and helpers for the multi-pop/multi-push free-pointer list.
package core_flst_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } flst_state_t;

  // CPU register map
  localparam logic CPADDR_STATUS = 1'b0;  // {headptr, freecnt}
  localparam logic CPADDR_ERRORS = 1'b1;  // {0.., ovf_err, unf_err}

  // Pointer written into slot idx during self-initialisation. The caller
  // truncates the result to its pointer width.
  function automatic logic [31:0] init_ptr(input logic [7:0]  ofst,
                                           input logic [31:0] idx,
                                           input int          bitaddr);
    logic [31:0] base;
    base = {24'd0, ofst} << bitaddr;
    return base | idx;
  endfunction

endpackage

// File: rtl/core_flst_grant.sv
// In-order grant: walks the request ports 0..NUMPT-1 and grants a port while
// the number already granted (its rank) is below that port's limit. Port 0
// has its own limit so a reserve can be held back for it.
module core_flst_grant #(
  parameter int NUMPT  = 2,
  parameter int BITCNT = 5
) (
  input  logic [NUMPT-1:0]        req,
  input  logic [BITCNT-1:0]       limit0,
  input  logic [BITCNT-1:0]       limitk,
  output logic [NUMPT-1:0]        gnt,
  output logic [NUMPT*BITCNT-1:0] rank,
  output logic [BITCNT-1:0]       count
);

  logic [BITCNT-1:0] acc;

  // Running count of grants; each port sees the count before itself as rank.
  always_comb begin
    acc  = '0;
    gnt  = '0;
    rank = '0;
    for (int k = 0; k < NUMPT; k++) begin
      rank[k*BITCNT +: BITCNT] = acc;
      if (req[k] && (acc < ((k == 0) ? limit0 : limitk))) begin
        gnt[k] = 1'b1;
        acc    = acc + BITCNT'(1);
      end
    end
  end

  assign count = acc;

endmodule

// File: rtl/core_mrnw_flst.sv
// Free-pointer list with ring storage: NUMPOPT same-cycle pop ports,
// NUMPUPT push ports, reserve for pop port 0, sticky errors, CPU access and
// a self-initialisation sequence writing INITWR slots per cycle.
//
// Handshake: a pop is a request (vpop[k]) answered in the same cycle by
// vpo_pvld[k]/vpo_ptr[k]; there is no backpressure, a refused pop is simply
// dropped and flagged in unf_err. Pushes are fire-and-forget; a push that
// does not fit is dropped and flagged in ovf_err.
module core_mrnw_flst
  import core_flst_pkg::*;
#(
  parameter int NUMADDR = 16,
  parameter int BITADDR = 4,
  parameter int BITQPTR = 5,
  parameter int BITQCNT = BITADDR + 1,
  parameter int NUMPOPT = 2,
  parameter int NUMPUPT = 2,
  parameter int INITWR  = 2,
  parameter int RSVCNT  = 0,
  parameter int LOWMARK = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rst_ofst,
  input  logic [NUMPOPT-1:0]           vpop,
  output logic [NUMPOPT-1:0]           vpo_pvld,
  output logic [NUMPOPT*BITQPTR-1:0]   vpo_ptr,
  input  logic [NUMPUPT-1:0]           vpush,
  input  logic [NUMPUPT*BITQPTR-1:0]   vpu_ptr,
  input  logic                         vcpread,
  input  logic                         vcpwrite,
  input  logic                         vcpaddr,
  input  logic [BITADDR+BITQCNT-1:0]   vcpdin,
  output logic                         vcpread_vld,
  output logic [BITADDR+BITQCNT-1:0]   vcpread_dout,
  output logic [BITQCNT-1:0]           freecnt,
  output logic                         lowmark,
  output logic                         ready
);

  localparam int DW = BITADDR + BITQCNT;
  localparam logic [BITADDR-1:0] LASTIDX = BITADDR'(NUMADDR - INITWR);

  logic [BITQPTR-1:0] mem [NUMADDR];

  flst_state_t        state, state_nx;
  logic               init_en, init_last;
  logic               ready_q, active;
  logic [BITADDR-1:0] initidx, headptr, tailptr;
  logic [BITQCNT-1:0] fcnt;
  logic               ovf_err, unf_err;
  logic               rd_vld;
  logic [DW-1:0]      rd_dout;

  logic [NUMPOPT-1:0]         pop_req, pop_gnt;
  logic [NUMPOPT*BITQCNT-1:0] pop_rank;
  logic [BITQCNT-1:0]         pop_cnt, pop_lim0, pop_limk;
  logic [NUMPUPT-1:0]         push_req, push_gnt;
  logic [NUMPUPT*BITQCNT-1:0] push_rank;
  logic [BITQCNT-1:0]         push_cnt, push_lim;
  logic [BITQPTR-1:0]         init_val [INITWR];
  logic                       cpu_load, err_clr, unf_evt, ovf_evt;

  // Traffic is only honoured once ready is visible and reset is not asserted.
  assign active = ready_q & rst;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= INIT;
    else      state <= state_nx;
  end

  // Next state: leave INIT after the last block of slots is written.
  always_comb begin
    state_nx = state;
    if (state == INIT && initidx == LASTIDX) state_nx = READY;
  end

  // FSM outputs.
  always_comb begin
    init_en   = (state == INIT);
    init_last = (state == INIT) && (initidx == LASTIDX);
  end

  // Pop limits: port 0 may use every free pointer, others leave RSVCNT behind.
  always_comb begin
    pop_req  = vpop & {NUMPOPT{active}};
    pop_lim0 = fcnt;
    pop_limk = (fcnt > BITQCNT'(RSVCNT)) ? fcnt - BITQCNT'(RSVCNT) : '0;
    push_req = vpush & {NUMPUPT{active}};
    // Pushes may refill the slots freed by this cycle's pops.
    push_lim = BITQCNT'(NUMADDR) - fcnt + pop_cnt;
  end

  core_flst_grant #(.NUMPT(NUMPOPT), .BITCNT(BITQCNT)) u_pop_grant (
    .req(pop_req), .limit0(pop_lim0), .limitk(pop_limk),
    .gnt(pop_gnt), .rank(pop_rank), .count(pop_cnt)
  );

  core_flst_grant #(.NUMPT(NUMPUPT), .BITCNT(BITQCNT)) u_push_grant (
    .req(push_req), .limit0(push_lim), .limitk(push_lim),
    .gnt(push_gnt), .rank(push_rank), .count(push_cnt)
  );

  // Pop data comes straight from the ring; pushes of this cycle are not visible.
  always_comb begin : pop_mux
    logic [BITADDR-1:0] ridx;
    vpo_ptr = '0;
    for (int k = 0; k < NUMPOPT; k++) begin
      ridx = headptr + BITADDR'(pop_rank[k*BITQCNT +: BITQCNT]);
      if (pop_gnt[k]) vpo_ptr[k*BITQPTR +: BITQPTR] = mem[ridx];
    end
  end

  // Init values for the INITWR slots written this cycle.
  always_comb begin
    for (int j = 0; j < INITWR; j++)
      init_val[j] = BITQPTR'(init_ptr(rst_ofst, 32'(initidx) + 32'(j), BITADDR));
  end

  always_comb begin
    cpu_load = active && vcpwrite && (vcpaddr == CPADDR_STATUS) &&
               !(|pop_gnt) && !(|push_gnt);
    err_clr  = vcpread && (vcpaddr == CPADDR_ERRORS);
    unf_evt  = |(pop_req & ~pop_gnt);
    ovf_evt  = |(push_req & ~push_gnt);
  end

  // Ring storage: init fill, then accepted pushes at tailptr+rank.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (init_en) begin
        for (int j = 0; j < INITWR; j++)
          mem[initidx + BITADDR'(j)] <= init_val[j];
      end else begin
        for (int k = 0; k < NUMPUPT; k++)
          if (push_gnt[k])
            mem[tailptr + BITADDR'(push_rank[k*BITQCNT +: BITQCNT])] <= vpu_ptr[k*BITQPTR +: BITQPTR];
      end
    end
  end

  // Pointers, count, errors, CPU read path and the registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      initidx <= '0;
      headptr <= '0;
      tailptr <= '0;
      fcnt    <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
      rd_vld  <= 1'b0;
      rd_dout <= '0;
    end else begin
      ready_q <= (state == READY);
      rd_vld  <= vcpread;
      if (vcpread)
        rd_dout <= (vcpaddr == CPADDR_ERRORS) ? DW'({ovf_err, unf_err}) : {headptr, fcnt};
      if (init_en) begin
        initidx <= initidx + BITADDR'(INITWR);
        if (init_last) fcnt <= BITQCNT'(NUMADDR);
      end else if (cpu_load) begin
        headptr <= vcpdin[DW-1:BITQCNT];
        fcnt    <= vcpdin[BITQCNT-1:0];
        tailptr <= vcpdin[DW-1:BITQCNT] + BITADDR'(vcpdin[BITQCNT-1:0]);
      end else if (active) begin
        headptr <= headptr + BITADDR'(pop_cnt);
        tailptr <= tailptr + BITADDR'(push_cnt);
        fcnt    <= fcnt - pop_cnt + push_cnt;
      end
      // An error raised this cycle survives a same-cycle clear.
      unf_err <= (unf_err & ~err_clr) | unf_evt;
      ovf_err <= (ovf_err & ~err_clr) | ovf_evt;
    end
  end

  assign vpo_pvld     = pop_gnt;
  assign vcpread_vld  = rd_vld;
  assign vcpread_dout = rd_dout;
  assign freecnt      = fcnt;
  assign lowmark      = (fcnt <= BITQCNT'(LOWMARK));
  assign ready        = ready_q;

endmodule

// File: tb/tb_core_mrnw_flst.sv
// Directed bench for core_mrnw_flst: init, drain, wrap, partial grants,
// overflow, push/pop concurrency, CPU access, reserve pool and mid-traffic reset.
module tb_core_mrnw_flst;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rst_ofst;

  logic [1:0]  vpop, vpo_pvld, vpush;
  logic [9:0]  vpo_ptr, vpu_ptr;
  logic        vcpread, vcpwrite, vcpaddr, vcpread_vld;
  logic [8:0]  vcpdin, vcpread_dout;
  logic [4:0]  freecnt;
  logic        lowmark, ready;

  logic [1:0]  r_vpop, r_vpo_pvld, r_vpush;
  logic [9:0]  r_vpo_ptr, r_vpu_ptr;
  logic        r_vcpread, r_vcpwrite, r_vcpaddr, r_vcpread_vld;
  logic [8:0]  r_vcpdin, r_vcpread_dout;
  logic [4:0]  r_freecnt;
  logic        r_lowmark, r_ready;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  core_mrnw_flst u_dut (
    .clk(clk), .rst(rst), .rst_ofst(rst_ofst),
    .vpop(vpop), .vpo_pvld(vpo_pvld), .vpo_ptr(vpo_ptr),
    .vpush(vpush), .vpu_ptr(vpu_ptr),
    .vcpread(vcpread), .vcpwrite(vcpwrite), .vcpaddr(vcpaddr), .vcpdin(vcpdin),
    .vcpread_vld(vcpread_vld), .vcpread_dout(vcpread_dout),
    .freecnt(freecnt), .lowmark(lowmark), .ready(ready)
  );

  core_mrnw_flst #(.RSVCNT(2)) u_rsv (
    .clk(clk), .rst(rst), .rst_ofst(rst_ofst),
    .vpop(r_vpop), .vpo_pvld(r_vpo_pvld), .vpo_ptr(r_vpo_ptr),
    .vpush(r_vpush), .vpu_ptr(r_vpu_ptr),
    .vcpread(r_vcpread), .vcpwrite(r_vcpwrite), .vcpaddr(r_vcpaddr), .vcpdin(r_vcpdin),
    .vcpread_vld(r_vcpread_vld), .vcpread_dout(r_vcpread_dout),
    .freecnt(r_freecnt), .lowmark(r_lowmark), .ready(r_ready)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic addr);
    vcpread = 1'b1;
    vcpaddr = addr;
    tick();
    vcpread = 1'b0;
  endtask

  task automatic cpu_write(input logic [8:0] din);
    vcpwrite = 1'b1;
    vcpaddr  = 1'b0;
    vcpdin   = din;
    tick();
    vcpwrite = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rst_ofst = 8'd1;
    vpop = '0; vpush = '0; vpu_ptr = '0;
    vcpread = 1'b0; vcpwrite = 1'b0; vcpaddr = 1'b0; vcpdin = '0;
    r_vpop = '0; r_vpush = '0; r_vpu_ptr = '0;
    r_vcpread = 1'b0; r_vcpwrite = 1'b0; r_vcpaddr = 1'b0; r_vcpdin = '0;

    // Reset state
    tick(); tick();
    vpop = 2'b11; #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_pvld", 32'(vpo_pvld), 32'd0);
    check("rst_rdvld", 32'(vcpread_vld), 32'd0);
    check("rst_freecnt", 32'(freecnt), 32'd0);
    vpop = 2'b00;

    // Init: ready one cycle after READY, 9 cycles after release
    rst = 1'b1;
    repeat (8) tick();
    check("init_ready_early", 32'(ready), 32'd0);
    check("init_freecnt", 32'(freecnt), 32'd16);
    tick();
    check("init_ready", 32'(ready), 32'd1);
    check("init_lowmark", 32'(lowmark), 32'd0);
    cpu_read(1'b0);
    check("init_rdvld", 32'(vcpread_vld), 32'd1);
    check("init_status", 32'(vcpread_dout), 32'h010);

    // Drain with dual pops
    for (int i = 0; i < 8; i++) begin
      vpop = 2'b11; #1;
      check("drain_pvld", 32'(vpo_pvld), 32'd3);
      check("drain_ptr", 32'(vpo_ptr), 32'({5'(5'h11 + 2*i), 5'(5'h10 + 2*i)}));
      tick();
    end
    vpop = 2'b00; #1;
    check("drain_freecnt", 32'(freecnt), 32'd0);
    check("drain_lowmark", 32'(lowmark), 32'd1);
    vpop = 2'b11; #1;
    check("empty_pvld", 32'(vpo_pvld), 32'd0);
    check("empty_ptr", 32'(vpo_ptr), 32'd0);
    tick();
    vpop = 2'b00;
    cpu_read(1'b1);
    check("unf_read", 32'(vcpread_dout), 32'd1);
    cpu_read(1'b1);
    check("unf_cleared", 32'(vcpread_dout), 32'd0);

    // Wrap: tailptr at 15, pushes straddle 15->0
    cpu_write({4'hF, 5'd0});
    cpu_read(1'b0);
    check("load_status", 32'(vcpread_dout), 32'h1E0);
    vpush = 2'b11; vpu_ptr = {5'h1E, 5'h1F};
    tick();
    vpu_ptr = {5'h1C, 5'h1D};
    tick();
    vpush = 2'b00;
    check("wrap_freecnt", 32'(freecnt), 32'd4);
    check("wrap_lowmark", 32'(lowmark), 32'd1);
    vpop = 2'b11; #1;
    check("wrap_pop0", 32'(vpo_ptr), 32'({5'h1E, 5'h1F}));
    tick();
    check("wrap_pop1", 32'(vpo_ptr), 32'({5'h1C, 5'h1D}));
    tick();
    vpop = 2'b00;
    check("wrap_empty", 32'(freecnt), 32'd0);

    // Partial grant with one free pointer
    vpush = 2'b01; vpu_ptr = {5'h00, 5'h05};
    tick();
    vpush = 2'b00;
    check("part_freecnt", 32'(freecnt), 32'd1);
    vpop = 2'b11; #1;
    check("part_pvld", 32'(vpo_pvld), 32'd1);
    check("part_ptr", 32'(vpo_ptr), 32'({5'h00, 5'h05}));
    tick();
    vpop = 2'b00;
    cpu_read(1'b1);
    check("part_unf", 32'(vcpread_dout), 32'd1);

    // CPU write ignored in a cycle with an accepted push
    vpush = 2'b01; vpu_ptr = {5'h00, 5'h07};
    vcpwrite = 1'b1; vcpaddr = 1'b0; vcpdin = 9'h1EF;
    tick();
    vcpwrite = 1'b0; vpush = 2'b00;
    cpu_read(1'b0);
    check("cpuwr_blocked", 32'(vcpread_dout), 32'h081);

    // Overflow at full
    cpu_write({4'h0, 5'd16});
    check("full_freecnt", 32'(freecnt), 32'd16);
    check("full_lowmark", 32'(lowmark), 32'd0);
    vpush = 2'b01; vpu_ptr = {5'h00, 5'h09};
    tick();
    vpush = 2'b00;
    check("ovf_freecnt", 32'(freecnt), 32'd16);
    cpu_read(1'b1);
    check("ovf_read", 32'(vcpread_dout), 32'd2);

    // Concurrency: pop frees room for a second push; no push-to-pop bypass
    vpop = 2'b01; #1;
    check("conc_pop0", 32'(vpo_ptr), 32'h01E);
    tick();
    check("conc_fc15", 32'(freecnt), 32'd15);
    vpush = 2'b11; vpu_ptr = {5'h0B, 5'h0A}; #1;
    check("conc_pvld", 32'(vpo_pvld), 32'd1);
    check("conc_pop1", 32'(vpo_ptr), 32'h01D);
    tick();
    vpop = 2'b00; vpush = 2'b00;
    check("conc_freecnt", 32'(freecnt), 32'd16);
    cpu_read(1'b1);
    check("conc_noerr", 32'(vcpread_dout), 32'd0);
    vpop = 2'b11; #1;
    check("conc_pop2", 32'(vpo_ptr), 32'({5'h05, 5'h1C}));
    vpop = 2'b00;

    // Reserve pool on the RSVCNT=2 instance
    r_vpop = 2'b11; #1;
    check("rsv_full_pvld", 32'(r_vpo_pvld), 32'd3);
    r_vpop = 2'b00;
    r_vcpwrite = 1'b1; r_vcpaddr = 1'b0; r_vcpdin = {4'h0, 5'd2};
    tick();
    r_vcpwrite = 1'b0;
    r_vpop = 2'b10; #1;
    check("rsv_port1_refused", 32'(r_vpo_pvld), 32'd0);
    r_vpop = 2'b11; #1;
    check("rsv_port0_only", 32'(r_vpo_pvld), 32'd1);
    check("rsv_ptr", 32'(r_vpo_ptr), 32'h010);
    r_vpop = 2'b00;

    // Reset mid-traffic, re-init with a new offset
    vpop = 2'b11;
    rst = 1'b0; rst_ofst = 8'd2; #1;
    check("mid_rst_pvld", 32'(vpo_pvld), 32'd0);
    tick();
    rst = 1'b1; #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_pvld2", 32'(vpo_pvld), 32'd0);
    check("mid_rst_freecnt", 32'(freecnt), 32'd0);
    repeat (8) tick();
    check("reinit_ready_early", 32'(ready), 32'd0);
    tick();
    check("reinit_ready", 32'(ready), 32'd1);
    check("reinit_freecnt", 32'(freecnt), 32'd16);
    check("reinit_ptr", 32'(vpo_ptr), 32'({5'h01, 5'h00}));
    vpop = 2'b00;

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_mrnw_flst.md
Name: core_mrnw_flst

Overview:
Multi-pop/multi-push free-pointer list. It is the parametrised successor of the banked free-pointer queue, with internal ring storage. It hands out buffer pointers on up to NUMPOPT pop ports and accepts returned pointers on up to NUMPUPT push ports per cycle. It adds features the previous generation lacked:
- per-port grant when pointers are scarce
- a reserve pool for port 0
- a low watermark output
- sticky overflow/underflow error flags
- a configurable-width self-initialisation sequence

It sits between the packet buffer allocator and the dequeue/free logic.

Parameters:
NUMADDR, 16, pointers managed; power of two.
BITADDR, 4, log2(NUMADDR).
BITQPTR, 5, pointer width; must be >= BITADDR.
BITQCNT, BITADDR+1, free-count width.
NUMPOPT, 2, pop ports.
NUMPUPT, 2, push ports.
INITWR, 2, entries written per init cycle; must divide NUMADDR.
RSVCNT, 0, entries only port 0 may consume.
LOWMARK, 4, watermark threshold.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets)
rst_ofst  in  8  pointer base; sampled during INIT
vpop  in  NUMPOPT  pop request per port
vpo_pvld  out  NUMPOPT  pop granted, same cycle
vpo_ptr  out  NUMPOPT*BITQPTR  granted pointers, port k at [k*BITQPTR +: BITQPTR]
vpush  in  NUMPUPT  push request per port
vpu_ptr  in  NUMPUPT*BITQPTR  pushed pointers
vcpread  in  1  CPU read
vcpwrite  in  1  CPU write
vcpaddr  in  1  0 = status, 1 = errors
vcpdin  in  BITADDR+BITQCNT  {headptr,freecnt} load value
vcpread_vld  out  1  read data valid
vcpread_dout  out  BITADDR+BITQCNT  read data
freecnt  out  BITQCNT  pointers available
lowmark  out  1  freecnt <= LOWMARK
ready  out  1  init complete

Behaviour:
- Reset (rst==0 at posedge): state <= INIT, initidx=0, headptr=0, tailptr=0, freecnt=0, errors=0.
  - Outputs during reset: ready=0, vpo_pvld=0, vcpread_vld=0.
  - Reset asserted mid-INIT or mid-traffic aborts everything and restarts INIT.
- FSM INIT -> READY.
  - INIT writes mem[initidx+j] = ((rst_ofst<<BITADDR) | (initidx+j)) truncated to BITQPTR, for j < INITWR.
  - initidx advances by INITWR each cycle. After the last write: freecnt=NUMADDR, state=READY.
  - ready is registered: it is 1 the cycle after READY is entered, i.e. NUMADDR/INITWR+1 cycles after reset releases.
- Push/pop are ignored while ready=0; no error flags are set.
- Pop grant, combinational, evaluated in port order 0..NUMPOPT-1:
  - rank = number of ports granted so far.
  - Port 0 is granted if rank < freecnt.
  - Port k>0 is granted if rank < freecnt-RSVCNT (saturating at 0).
  - vpo_ptr[k] = mem[(headptr+rank)%NUMADDR]; it is 0 when not granted.
  - Zero latency. A pop request that is refused sets sticky unf_err.
- Push: each vpush[k] is accepted in order while freecnt - popgnt + accepted < NUMADDR.
  - Accepted pushes write mem[(tailptr+rank)%NUMADDR].
  - Excess pushes are dropped and set sticky ovf_err.
- Simultaneous push+pop: pops see only pre-cycle contents, with no push-to-pop bypass.
  - Next freecnt = freecnt - popgnt + pushacc.
  - headptr += popgnt, tailptr += pushacc, both mod NUMADDR (natural wrap).
- lowmark and freecnt are registered-state outputs.
- CPU access:
  - Read latency is 1 cycle. vcpread_dout = addr0 ? {headptr,freecnt} : {0..,ovf_err,unf_err}.
  - A read of addr1 clears both errors; a same-cycle error event wins over the clear.
  - A write to addr0 loads headptr/freecnt and sets tailptr = (headptr+freecnt)%NUMADDR, but only in a cycle with no granted pop and no accepted push; otherwise the write is ignored.
  - Writes to addr1 are ignored. CPU access during INIT: reads return current state; writes are ignored.

Decomposition:
- Package core_flst_pkg: FSM enum {INIT,READY}, CPU address constants, and a function computing the init pointer value.
- One sub-module, core_flst_grant: combinational in-order grant/rank computation, parametrised by port count, used for both pop (with reserve) and push (capacity limit).

Test Plan:
- Init: release rst with rst_ofst=1 -> ready=1 at cycle 9; freecnt=16; vpop=2'b11 returns 5'h10, 5'h11.
- Drain: dual pop for 8 cycles -> freecnt=0, lowmark=1; then vpop=11 -> vpo_pvld=00, unf_err=1; CPU read addr1 next cycle returns 2'b01, then reads as 0.
- Partial: freecnt=1, vpop=11 -> vpo_pvld=01; with RSVCNT=2 and freecnt=2, vpop=10 -> refused.
- Wrap order: drain, push 0x1F,0x1E then 0x1D,0x1C as tailptr wraps 15->0 -> subsequent pops return 0x1F,0x1E,0x1D,0x1C.
- Overflow/concurrency: at freecnt=16, vpush=01 -> dropped, ovf_err=1. At freecnt=15, vpop=01 with vpush=11 -> both pushes accepted, freecnt=16.
- Reset mid-traffic: rst=0 for one cycle during dual pop -> vpo_pvld=0 and ready=0 next cycle; re-init completes after 9 cycles with freecnt=16.
